// File: rtl/async_fifo.sv
// async_fifo: single-clock show-ahead FIFO with wrap-bit pointers, fill count and overflow/underflow pulses
module async_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             win,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rout,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  logic [DSIZE-1:0] mem [2**ASIZE];
  logic [ASIZE:0] wptr, rptr;
  logic do_w, do_r;
  assign rempty = wptr == rptr;
  assign wfull = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) && (wptr[ASIZE] != rptr[ASIZE]);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[ASIZE-1:0]];
  assign do_w = win && !wfull;
  assign do_r = rout && !rempty;
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr <= wptr + (ASIZE+1)'(do_w);
      rptr <= rptr + (ASIZE+1)'(do_r);
      overflow <= win && wfull;
      underflow <= rout && rempty;
    end
  end
  always_ff @(posedge wclk)
    if (wrst_n && do_w) mem[wptr[ASIZE-1:0]] <= wdata;
endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: scoreboard bench; stimulus pushes accepted words, a negedge monitor checks every pop
module tb_async_fifo;
  logic wclk = 1'b0, wrst_n = 1'b0, win = 1'b0, rout = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic wfull, rempty, overflow, underflow;
  logic [7:0] rdata;
  logic [4:0] count;
  int checks = 0, errors = 0, mcount = 0;
  logic [7:0] sb[$];
  logic [7:0] popped;

  async_fifo #(.DSIZE(8), .ASIZE(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .win(win), .wdata(wdata), .wfull(wfull),
    .rout(rout), .rdata(rdata), .rempty(rempty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge wclk)
    if (wrst_n && rout && !rempty) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop: got %0h expected no word (model empty) at %0t", rdata, $time);
      end else begin
        popped = sb.pop_front();
        chk("pop", 32'(rdata), 32'(popped));
      end
    end

  task automatic step(bit w, logic [7:0] d, bit r);
    bit wo, ro;
    wo = w && mcount < 16;
    ro = r && mcount > 0;
    win = w;
    wdata = d;
    rout = r;
    if (wo) sb.push_back(d);
    @(posedge wclk);
    #1;
    mcount = mcount + int'(wo) - int'(ro);
    chk("count", 32'(count), 32'(mcount));
    chk("rempty", 32'(rempty), 32'(mcount == 0));
    chk("wfull", 32'(wfull), 32'(mcount == 16));
    chk("overflow", 32'(overflow), 32'(w && !wo));
    chk("underflow", 32'(underflow), 32'(r && !ro));
    if (mcount > 0) chk("rdata_head", 32'(rdata), 32'(sb[0]));
    win = 1'b0;
    rout = 1'b0;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    win = 1'b1;
    rout = 1'b1;
    wdata = 8'hFF;
    @(posedge wclk);
    #1;
    sb.delete();
    mcount = 0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_wfull", 32'(wfull), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    wrst_n = 1'b1;
    win = 1'b0;
    rout = 1'b0;
  endtask

  initial begin
    int n;
    bit w, r;
    @(posedge wclk);
    #1;
    do_reset();
    step(0, 8'h00, 0);
    step(1, 8'hA5, 0);
    chk("a5_head", 32'(rdata), 32'hA5);
    step(0, 8'h00, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    step(1, 8'hFF, 0);
    step(0, 8'h00, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0);
    step(1, 8'hEE, 1);
    chk("full_wr_rd_count", 32'(count), 32'd15);
    while (mcount > 0) step(0, 8'h00, 1);
    n = 0;
    for (int k = 0; k < 400 && n < 40; k++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (w && mcount < 16) n++;
      step(w, 8'($urandom), r);
    end
    chk("rand_words", 32'(n), 32'd40);
    for (int k = 0; k < 20 && mcount > 0; k++) step(0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0);
    do_reset();
    step(1, 8'h3C, 0);
    chk("post_rst_head", 32'(rdata), 32'h3C);
    step(0, 8'h00, 1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 The module SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter DSIZE SHALL default to 8 and set the data word width in bits.
REQ-003 Parameter ASIZE SHALL default to 4 and set the address width, giving depth 2**ASIZE (16 words).
REQ-004 Port wclk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port wrst_n SHALL be an input, 1 bit: synchronous active-low reset.
REQ-006 Port win SHALL be an input, 1 bit: write request.
REQ-007 Port wdata SHALL be an input, DSIZE bits: write data.
REQ-008 Port wfull SHALL be an output, 1 bit: FIFO full.
REQ-009 Port rout SHALL be an input, 1 bit: read request (pop).
REQ-010 Port rdata SHALL be an output, DSIZE bits: head-of-queue data in show-ahead (first-word-fall-through) form.
REQ-011 Port rempty SHALL be an output, 1 bit: FIFO empty.
REQ-012 Port count SHALL be an output, ASIZE+1 bits: number of stored words, 0..2**ASIZE.
REQ-013 Port overflow SHALL be an output, 1 bit: one-cycle pulse when a write was refused because the FIFO was full.
REQ-014 Port underflow SHALL be an output, 1 bit: one-cycle pulse when a read was refused because the FIFO was empty.

Function
REQ-015 Storage SHALL be a 2**ASIZE x DSIZE array; the write and read pointers SHALL each be ASIZE+1 bits (address plus wrap bit).
REQ-016 Write: on a rising edge with win=1 and wfull=0, wdata SHALL be stored at wptr[ASIZE-1:0], and wptr SHALL increment modulo 2**(ASIZE+1).
REQ-017 Read: on a rising edge with rout=1 and rempty=0, rptr SHALL increment modulo 2**(ASIZE+1).
REQ-018 rdata SHALL equal mem[rptr[ASIZE-1:0]] combinationally, so the head word is valid whenever rempty=0, before and during the cycle in which rout pops it.
REQ-019 rempty SHALL be 1 exactly when wptr equals rptr.
REQ-020 wfull SHALL be 1 exactly when the address bits of wptr and rptr are equal and their wrap bits differ.
REQ-021 count SHALL equal (wptr - rptr) modulo 2**(ASIZE+1).
REQ-022 rempty, wfull and count SHALL all be combinational from the registered pointers.
REQ-023 Latency: a word written at edge N SHALL appear on rdata, and clear rempty, immediately after edge N; it SHALL be poppable at edge N+1.
REQ-024 A simultaneous write and read when neither wfull nor rempty is set SHALL both take effect, leaving count unchanged.
REQ-025 When full, a write SHALL be refused even if a read occurs on the same edge; the read SHALL proceed.
REQ-026 When empty, a read SHALL be refused even if a write occurs on the same edge; the write SHALL proceed.
REQ-027 A refused write SHALL leave memory and wptr unchanged and set overflow=1 for the next cycle only.
REQ-028 A refused read SHALL leave rptr unchanged and set underflow=1 for the next cycle only.
REQ-029 Data SHALL emerge in exact write order across pointer wrap-around, with no loss or duplication.
REQ-030 rdata SHALL be don't-care while rempty=1.

Reset
REQ-031 On a rising edge with wrst_n=0, wptr, rptr, overflow and underflow SHALL be cleared to 0; consequently rempty=1, wfull=0 and count=0.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset SHALL take priority over simultaneous win or rout.
REQ-034 A reset asserted mid-operation SHALL discard all stored words.
REQ-035 win and rout SHALL be ignored while wrst_n=0.

Verification
REQ-036 Reset then idle -> rempty=1, wfull=0, count=0, overflow=0, underflow=0.
REQ-037 Write 0xA5 -> immediately after that edge, rdata=0xA5, rempty=0, count=1; a pop on the next edge -> rempty=1, count=0.
REQ-038 Write 16 words 0x00..0x0F -> wfull=1, count=16; a 17th write of 0xFF -> overflow pulses once and contents are unchanged; 16 pops return 0x00..0x0F in order.
REQ-039 Continuous random interleaved writes and reads totalling 40 words, exercising pointer wrap-around -> every popped rdata matches a reference queue in order.
REQ-040 Pop while empty -> underflow pulses once, rptr unchanged; simultaneous write+read at full -> write refused, read proceeds, count=15.
REQ-041 Reset asserted with 5 words stored -> after the edge, rempty=1 and count=0; a subsequent write of 0x3C is read back correctly.
